// File: rtl/trig_sweep_ctrl_pkg.sv
// Shared definitions for the trig sweep sequencer.
// Contents: default parameter widths, FSM state encodings, and a small
// helper that decodes the "busy" condition from a state value.
package trig_sweep_ctrl_pkg;

  localparam int VALUE_WIDTH_DEF = 32;
  localparam int ANGLE_WIDTH_DEF = 10;
  localparam int COUNT_WIDTH_DEF = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // A sweep is in progress while emitting samples or waiting for the last accept.
  function automatic logic is_busy_state(input logic [1:0] st);
    return (st == ST_RUN) || (st == ST_DRAIN);
  endfunction

endpackage

// File: rtl/trig_sweep_ctrl_table.sv
// trig_table: combinational signed sine/cosine of an angle index.
// A full circle is 2**ANGLE_WIDTH steps. Values are scaled to the largest
// positive VALUE_WIDTH-bit signed number (exact at the quarter points).
// Ports:
//   angle_in  in   ANGLE_WIDTH  angle index
//   sin_out   out  VALUE_WIDTH  signed sine
//   cos_out   out  VALUE_WIDTH  signed cosine
module trig_table
  import trig_sweep_ctrl_pkg::*;
#(
  parameter int VALUE_WIDTH = VALUE_WIDTH_DEF,
  parameter int ANGLE_WIDTH = ANGLE_WIDTH_DEF
) (
  input  logic        [ANGLE_WIDTH-1:0] angle_in,
  output logic signed [VALUE_WIDTH-1:0] sin_out,
  output logic signed [VALUE_WIDTH-1:0] cos_out
);

  localparam int PW = 2 * ANGLE_WIDTH + VALUE_WIDTH;
  // Half circle in angle steps.
  localparam logic [PW-1:0] HALF_C = PW'(1'b1) << (ANGLE_WIDTH - 1);
  // Full-scale positive value.
  localparam logic [PW-1:0] VMAX_C = (PW'(1'b1) << (VALUE_WIDTH - 1)) - PW'(1'b1);
  // 5/4 * HALF^2, the constant term of the rational approximation's denominator.
  localparam logic [PW-1:0] DEN0_C = PW'(3'd5) << (2 * ANGLE_WIDTH - 4);
  localparam logic [ANGLE_WIDTH-1:0] QUARTER_C = {2'b01, {(ANGLE_WIDTH - 2){1'b0}}};

  // Half-wave rational approximation: with u in [0, HALF) and p = u*(HALF-u),
  // |sin| = 4p / (5/4*HALF^2 - p). The MSB of the angle selects the negative half.
  function automatic logic signed [VALUE_WIDTH-1:0] sine_of(input logic [ANGLE_WIDTH-1:0] a);
    logic [PW-1:0]          u;
    logic [PW-1:0]          p;
    logic [PW-1:0]          num;
    logic [PW-1:0]          den;
    logic [VALUE_WIDTH-1:0] mag;
    u   = PW'(a[ANGLE_WIDTH-2:0]);
    p   = u * (HALF_C - u);
    num = (p << 2'd2) * VMAX_C;
    den = DEN0_C - p;
    mag = VALUE_WIDTH'(num / den);
    if (a[ANGLE_WIDTH-1]) begin
      sine_of = -$signed(mag);
    end else begin
      sine_of = $signed(mag);
    end
  endfunction

  // Cosine is the sine a quarter turn ahead; the add wraps modulo the circle.
  always_comb begin
    sin_out = sine_of(angle_in);
    cos_out = sine_of(angle_in + QUARTER_C);
  end

endmodule

// File: rtl/trig_sweep_ctrl.sv
// trig_sweep_ctrl: sequences a programmed sweep of angles (start, step,
// count) through trig_table and presents registered (angle, sin, cos)
// samples on a valid/ready stream, one sample per accepted beat.
// Optional feature macro: TRIG_SWEEP_CONT_EN adds input cfg_continuous,
// enabling endless periodic sweeps (no DRAIN, no done; stop by abort/rst).
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   start, abort                 sweep request / immediate termination
//   cfg_start_angle, cfg_step    first angle and per-sample increment
//   cfg_count                    samples per sweep (0 = immediate done)
//   busy, done                   sweep active / completion pulse
//   out_valid, out_ready         output handshake
//   out_angle, out_sin, out_cos  current sample
//   out_last                     final sample of a sweep or period
module trig_sweep_ctrl
  import trig_sweep_ctrl_pkg::*;
#(
  parameter int VALUE_WIDTH = VALUE_WIDTH_DEF,
  parameter int ANGLE_WIDTH = ANGLE_WIDTH_DEF,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic        [ANGLE_WIDTH-1:0] cfg_start_angle,
  input  logic        [ANGLE_WIDTH-1:0] cfg_step,
  input  logic        [COUNT_WIDTH-1:0] cfg_count,
`ifdef TRIG_SWEEP_CONT_EN
  input  logic                          cfg_continuous,
`endif
  output logic                          busy,
  output logic                          done,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic        [ANGLE_WIDTH-1:0] out_angle,
  output logic signed [VALUE_WIDTH-1:0] out_sin,
  output logic signed [VALUE_WIDTH-1:0] out_cos,
  output logic                          out_last
);

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1'b1);

  logic [1:0]                    state_q, state_d;
  logic [ANGLE_WIDTH-1:0]        angle_q, angle_d;
  logic [ANGLE_WIDTH-1:0]        step_q, step_d;
  logic [COUNT_WIDTH-1:0]        remain_q, remain_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          out_valid_q, out_valid_d;
  logic                          out_last_q, out_last_d;
  logic [ANGLE_WIDTH-1:0]        out_angle_q, out_angle_d;
  logic signed [VALUE_WIDTH-1:0] out_sin_q, out_sin_d;
  logic signed [VALUE_WIDTH-1:0] out_cos_q, out_cos_d;
  logic signed [VALUE_WIDTH-1:0] tbl_sin_s, tbl_cos_s;
  logic                          slot_free_s;
`ifdef TRIG_SWEEP_CONT_EN
  logic                          cont_q, cont_d;
  logic [COUNT_WIDTH-1:0]        count_q, count_d;
`endif

  trig_table #(
    .VALUE_WIDTH (VALUE_WIDTH),
    .ANGLE_WIDTH (ANGLE_WIDTH)
  ) u_trig_table (
    .angle_in (angle_q),
    .sin_out  (tbl_sin_s),
    .cos_out  (tbl_cos_s)
  );

  // Next-state logic: sweep sequencing, output-register loading, abort override.
  always_comb begin
    state_d     = state_q;
    angle_d     = angle_q;
    step_d      = step_q;
    remain_d    = remain_q;
    done_d      = 1'b0;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_angle_d = out_angle_q;
    out_sin_d   = out_sin_q;
    out_cos_d   = out_cos_q;
`ifdef TRIG_SWEEP_CONT_EN
    cont_d      = cont_q;
    count_d     = count_q;
`endif
    // The output register may take a new sample when empty or being drained this edge.
    slot_free_s = !out_valid_q || out_ready;

    if (abort) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (cfg_count != '0) begin
              angle_d  = cfg_start_angle;
              step_d   = cfg_step;
              remain_d = cfg_count;
`ifdef TRIG_SWEEP_CONT_EN
              cont_d   = cfg_continuous;
              count_d  = cfg_count;
`endif
              state_d  = ST_RUN;
            end else begin
              done_d = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (slot_free_s) begin
            out_valid_d = 1'b1;
            out_angle_d = angle_q;
            out_sin_d   = tbl_sin_s;
            out_cos_d   = tbl_cos_s;
            angle_d     = angle_q + step_q;
            remain_d    = remain_q - CNT_ONE;
            if (remain_q == CNT_ONE) begin
              out_last_d = 1'b1;
`ifdef TRIG_SWEEP_CONT_EN
              if (cont_q) begin
                remain_d = count_q;
              end else begin
                state_d = ST_DRAIN;
              end
`else
              state_d = ST_DRAIN;
`endif
            end else begin
              out_last_d = 1'b0;
            end
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
      endcase
    end
    busy_d = is_busy_state(state_d);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      angle_q     <= '0;
      step_q      <= '0;
      remain_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_angle_q <= '0;
      out_sin_q   <= '0;
      out_cos_q   <= '0;
`ifdef TRIG_SWEEP_CONT_EN
      cont_q      <= 1'b0;
      count_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      angle_q     <= angle_d;
      step_q      <= step_d;
      remain_q    <= remain_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_angle_q <= out_angle_d;
      out_sin_q   <= out_sin_d;
      out_cos_q   <= out_cos_d;
`ifdef TRIG_SWEEP_CONT_EN
      cont_q      <= cont_d;
      count_q     <= count_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_angle = out_angle_q;
  assign out_sin   = out_sin_q;
  assign out_cos   = out_cos_q;

endmodule

// File: tb/tb_trig_sweep_ctrl.sv
// Self-checking bench for trig_sweep_ctrl: table-driven sweeps, hand-written
// abort / start-ignore sequences, randomized sweeps with random backpressure,
// and (when TRIG_SWEEP_CONT_EN is defined) a continuous-mode sequence.
module tb_trig_sweep_ctrl;

  localparam int AW = 10;
  localparam int VW = 32;
  localparam int CW = 16;
  localparam int CIRCLE = 1 << AW;
  localparam real FULL = 2147483647.0;
  localparam real TOL  = 0.003 * 2147483648.0;
  localparam real TWO_PI = 6.283185307179586;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 abort;
  logic        [AW-1:0] cfg_start_angle;
  logic        [AW-1:0] cfg_step;
  logic        [CW-1:0] cfg_count;
`ifdef TRIG_SWEEP_CONT_EN
  logic                 cfg_continuous;
`endif
  logic                 busy;
  logic                 done;
  logic                 out_valid;
  logic                 out_ready;
  logic        [AW-1:0] out_angle;
  logic signed [VW-1:0] out_sin;
  logic signed [VW-1:0] out_cos;
  logic                 out_last;

  int n_checks = 0;
  int n_fail   = 0;

  trig_sweep_ctrl #(.VALUE_WIDTH(VW), .ANGLE_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .cfg_start_angle (cfg_start_angle),
    .cfg_step        (cfg_step),
    .cfg_count       (cfg_count),
`ifdef TRIG_SWEEP_CONT_EN
    .cfg_continuous  (cfg_continuous),
`endif
    .busy            (busy),
    .done            (done),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_angle       (out_angle),
    .out_sin         (out_sin),
    .out_cos         (out_cos),
    .out_last        (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Ideal trig value, full-scale, with a tolerance for the table's approximation.
  task automatic chk_near(input string name, input longint act, input real ideal);
    real d;
    n_checks++;
    d = real'(act) - ideal;
    if (d < 0.0) d = -d;
    if (d > TOL) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected about %0d", name, act, longint'(ideal));
    end
  endtask

  function automatic real ideal_sin(input int a);
    return $sin(TWO_PI * real'(a) / real'(CIRCLE)) * FULL;
  endfunction

  function automatic real ideal_cos(input int a);
    return $cos(TWO_PI * real'(a) / real'(CIRCLE)) * FULL;
  endfunction

  // Runs one single-shot sweep. Cycle 1 is the cycle after the start edge.
  // Every accepted sample is checked against angle = (sa + k*st) mod circle;
  // stalled outputs must hold. 'hold' forces ready low for the first N valid
  // cycles; 'poke' pulses start with different cfg mid-sweep.
  task automatic run_sweep(input int sa, input int st, input int cnt, input int pct,
                           input int hold, input bit poke,
                           output int n_seen, output int last_ang,
                           output int done_cyc, output int first_cyc);
    logic        [AW-1:0] p_ang;
    logic signed [VW-1:0] p_sin;
    logic signed [VW-1:0] p_cos;
    logic                 p_last;
    bit stalled;
    bit finished;
    int held;
    int exp_a;
    n_seen = 0; last_ang = -1; done_cyc = -1; first_cyc = -1;
    stalled = 1'b0; finished = 1'b0; held = 0;
    p_ang = '0; p_sin = '0; p_cos = '0; p_last = 1'b0;
    cfg_start_angle = AW'(sa);
    cfg_step        = AW'(st);
    cfg_count       = CW'(cnt);
    start           = 1'b1;
    out_ready       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 400 && !finished; cyc++) begin
      if (poke) begin
        if (cyc == 3) begin
          start           = 1'b1;
          cfg_start_angle = ~AW'(sa);
          cfg_count       = 16'd1;
        end else begin
          start = 1'b0;
        end
      end
      if (stalled) begin
        chk("stall_angle", out_angle, p_ang);
        chk("stall_sin", out_sin, p_sin);
        chk("stall_cos", out_cos, p_cos);
        chk("stall_last", out_last, p_last);
        chk("stall_valid", out_valid, 1);
      end
      if (out_valid && first_cyc < 0) first_cyc = cyc;
      if (out_valid && held < hold) begin
        out_ready = 1'b0;
        held++;
      end else begin
        out_ready = (int'($urandom_range(99)) < pct);
      end
      if (out_valid && out_ready) begin
        exp_a = (sa + n_seen * st) % CIRCLE;
        chk("angle", out_angle, exp_a);
        chk_near("sin", out_sin, ideal_sin(exp_a));
        chk_near("cos", out_cos, ideal_cos(exp_a));
        chk("last_flag", out_last, (n_seen == cnt - 1) ? 1 : 0);
        if (out_last) last_ang = int'(out_angle);
        n_seen++;
      end
      stalled = out_valid && !out_ready;
      p_ang = out_angle; p_sin = out_sin; p_cos = out_cos; p_last = out_last;
      if (done) begin
        done_cyc = cyc;
        finished = 1'b1;
        chk("done_after_all_samples", n_seen, cnt);
      end
      @(negedge clk);
    end
    if (!finished) chk("sweep_timeout", 0, 1);
    chk("done_one_cycle", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_valid", out_valid, 0);
    start     = 1'b0;
    out_ready = 1'b0;
  endtask

  typedef struct {
    int sa; int st; int cnt; int pct; int hold; bit poke;
    int exp_n; int exp_last; int exp_done_cyc; int exp_first_cyc;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n_seen, last_ang, done_cyc, first_cyc;
    bit found, saw_done, saw_valid;
    int n;

    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_seen, last_ang, done_cyc, first_cyc;
    bit found, saw_done, saw_valid;
    int sa, st, cnt;

    //          sa    st   cnt pct hold poke  n  last  done first
    vecs[0] = '{0,    1,   4, 100, 0, 1'b0, 4,    3,  6,  2};
    vecs[1] = '{1020, 3,   3, 100, 0, 1'b0, 3,    2,  5,  2};
    vecs[2] = '{100,  7,   3, 100, 5, 1'b0, 3,  114, 10,  2};
    vecs[3] = '{0,    0,   0, 100, 0, 1'b0, 0,   -1,  1, -1};
    vecs[4] = '{5,    0,   2, 100, 0, 1'b0, 2,    5,  4,  2};
    vecs[5] = '{1000, 100, 5, 100, 0, 1'b1, 5,  376,  7,  2};
    vecs[6] = '{1023, 1,   2, 100, 0, 1'b0, 2,    0,  4,  2};
    vecs[7] = '{0,    256, 4, 100, 0, 1'b0, 4,  768,  6,  2};

    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    cfg_start_angle = '0; cfg_step = '0; cfg_count = '0;
`ifdef TRIG_SWEEP_CONT_EN
    cfg_continuous = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_angle", out_angle, 0);
    chk("rst_sin", out_sin, 0);
    chk("rst_cos", out_cos, 0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven sweeps.
    for (int i = 0; i < 8; i++) begin
      run_sweep(vecs[i].sa, vecs[i].st, vecs[i].cnt, vecs[i].pct, vecs[i].hold,
                vecs[i].poke, n_seen, last_ang, done_cyc, first_cyc);
      chk($sformatf("vec%0d_count", i), n_seen, vecs[i].exp_n);
      chk($sformatf("vec%0d_last_angle", i), last_ang, vecs[i].exp_last);
      chk($sformatf("vec%0d_done_cycle", i), done_cyc, vecs[i].exp_done_cyc);
      chk($sformatf("vec%0d_first_valid_cycle", i), first_cyc, vecs[i].exp_first_cyc);
      @(negedge clk);
    end

    // Abort on the second sample of an 8-sample sweep.
    cfg_start_angle = 10'd0; cfg_step = 10'd1; cfg_count = 16'd8;
    start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (out_valid && out_angle == 10'd1) found = 1'b1;
      else @(negedge clk);
    end
    chk("abort_reached_2nd_sample", found, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_last", out_last, 0);
    chk("abort_done", done, 0);
    saw_done = 1'b0; saw_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
      if (out_valid) saw_valid = 1'b1;
    end
    chk("abort_no_done_later", saw_done, 0);
    chk("abort_no_valid_later", saw_valid, 0);

    // Start together with abort in IDLE is ignored.
    cfg_count = 16'd4; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_done", done, 0);
    @(negedge clk);
    chk("start_abort_valid", out_valid, 0);
    chk("start_abort_busy2", busy, 0);

    // Randomized sweeps with random backpressure.
    for (int r = 0; r < 6; r++) begin
      sa  = int'($urandom_range(CIRCLE - 1));
      st  = int'($urandom_range(CIRCLE - 1));
      cnt = int'($urandom_range(12, 1));
      run_sweep(sa, st, cnt, int'($urandom_range(100, 30)), int'($urandom_range(3)),
                1'b0, n_seen, last_ang, done_cyc, first_cyc);
      chk($sformatf("rand%0d_count", r), n_seen, cnt);
      chk($sformatf("rand%0d_last_angle", r), last_ang, (sa + (cnt - 1) * st) % CIRCLE);
      chk($sformatf("rand%0d_done_seen", r), (done_cyc > 0) ? 1 : 0, 1);
      @(negedge clk);
    end

`ifdef TRIG_SWEEP_CONT_EN
    // Continuous sweep: period of 2, quarter-turn step, runs until abort.
    begin
      int k;
      cfg_continuous = 1'b1;
      cfg_start_angle = 10'd0; cfg_step = 10'd256; cfg_count = 16'd2;
      start = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      for (int c = 0; c < 40 && k < 8; c++) begin
        if (out_valid) begin
          chk("cont_angle", out_angle, (k * 256) % CIRCLE);
          chk("cont_last", out_last, k % 2);
          chk_near("cont_sin", out_sin, ideal_sin((k * 256) % CIRCLE));
          k++;
        end
        chk("cont_no_done", done, 0);
        @(negedge clk);
      end
      chk("cont_sample_count", k, 8);
      chk("cont_still_busy", busy, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      cfg_continuous = 1'b0;
      chk("cont_abort_busy", busy, 0);
      chk("cont_abort_valid", out_valid, 0);
      chk("cont_abort_done", done, 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
